// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
//   Request/response bundle between the core's MAR/MDR path and mem_ctrl.
//
//   Signals:
//     rd_req, wr_req : single-cycle read / write requests from the core
//     addr           : word address, captured with the request
//     wdata          : write data, captured with the request
//     rdata          : read data, valid in the done cycle of a read and held
//     busy           : request in flight; the core stalls on it
//     done           : one-cycle completion pulse
//     err            : one-cycle pulse, coincident with done, on a rejected request
//
//   Modports:
//     master : the core side (drives requests, observes responses)
//     slave  : the controller side
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) ();
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output rd_req, wr_req, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  rd_req, wr_req, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Handshaked single-port memory controller owning a DEPTH x DATA_W array.
//   One read or write is served at a time: the request is captured in IDLE,
//   WAIT_STATES wait cycles follow, then the array is accessed and a done
//   pulse is issued one cycle later. Out-of-range addresses and simultaneous
//   read+write requests are rejected with err (coincident with done).
//
//   Parameters:
//     DATA_W      : word width
//     ADDR_W      : address width
//     DEPTH       : implemented words (DEPTH <= 2**ADDR_W)
//     WAIT_STATES : wait cycles before each access, 0..15
//
//   Ports:
//     clk      : system clock, rising edge
//     reset    : synchronous, active-high reset (array contents are kept)
//     bus      : mem_ctrl_if.slave request/response bundle
//     rd_count : successful reads, saturating  (MEM_CTRL_ACCESS_CNT_EN only)
//     wr_count : successful writes, saturating (MEM_CTRL_ACCESS_CNT_EN only)
//
//   Optional feature macro: MEM_CTRL_ACCESS_CNT_EN
//     When defined, adds the rd_count / wr_count access counters.
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_ctrl_if.slave   bus
`ifdef MEM_CTRL_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_e;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Full-width bound so DEPTH == 2**ADDR_W does not truncate to zero.
    localparam logic [ADDR_W:0] DEPTH_BOUND = (ADDR_W + 1)'(DEPTH);

    // Last wait-counter value; the WAIT state is unreachable when WAIT_STATES == 0.
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state_q,    state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              is_rd_q,    is_rd_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    logic              mem_we;
    logic              addr_ok;
    logic [IDX_W-1:0]  mem_idx;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign addr_ok = ({1'b0, addr_q} < DEPTH_BOUND);
    assign mem_idx = addr_q[IDX_W-1:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        is_rd_d    = is_rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rd_req && bus.wr_req) begin
                    // Conflicting request: reject without touching the array.
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (bus.rd_req || bus.wr_req) begin
                    is_rd_d    = bus.rd_req;
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    busy_d     = 1'b1;
                    wait_cnt_d = 4'd0;
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end

            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 4'd0;
                    state_d    = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            ST_ACCESS: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!addr_ok) begin
                    err_d = 1'b1;
                end else if (is_rd_q) begin
                    rdata_d = mem_q[mem_idx];
                end else begin
                    mem_we = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            is_rd_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            is_rd_q    <= is_rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Word array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset so it maps onto RAM; only the write enable
    // is qualified by reset, so a reset on the ACCESS edge abandons the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

`ifdef MEM_CTRL_ACCESS_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating access counters: bumped on the ACCESS edge of a successful
    // operation, i.e. the same edge that raises done with err=0.
    // -------------------------------------------------------------------------
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_q == ST_ACCESS && addr_ok) begin
            if (is_rd_q && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
            if (!is_rd_q && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
